// File: rtl/fifo_rd_ctrl_if.sv
// Downstream valid/ready read port of the async FIFO read-side controller.
//   rd_valid : master -> slave, rd_data holds a valid word
//   rd_ready : slave -> master, rd_data is accepted this cycle
//   rd_data  : master -> slave, output word
interface fifo_rd_ctrl_if #(
    parameter int unsigned data = 14
);
    logic            rd_valid;
    logic            rd_ready;
    logic [data-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: owns the binary/Gray read pointer,
// the empty flag, the fill level and a registered show-ahead output stage.
// Optional feature: define RD_ALMOST_EMPTY_EN to add the raempty port and the
// AE_LEVEL parameter.
// Ports:
//   rclk, rrst_n : read clock, asynchronous active-low reset
//   rq2_wptr     : Gray write pointer, already synchronized into rclk
//   mem_rdata    : memory read data, combinational from raddr
//   raddr        : memory read address (low bits of the binary read pointer)
//   rptr         : registered Gray read pointer for the write-domain synchronizer
//   rempty       : memory empty (output register not included), registered
//   rlevel       : words in memory not yet pulled, 0..DEPTH
//   raempty      : almost empty, registered (RD_ALMOST_EMPTY_EN only)
//   rd           : downstream valid/ready port (master side)
module fifo_rd_ctrl #(
    parameter int unsigned data     = 14,
    parameter int unsigned addr     = 4
`ifdef RD_ALMOST_EMPTY_EN
    ,
    parameter int unsigned AE_LEVEL = 2
`endif
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic [addr:0]     rq2_wptr,
    input  logic [data-1:0]   mem_rdata,
    output logic [addr-1:0]   raddr,
    output logic [addr:0]     rptr,
    output logic              rempty,
    output logic [addr:0]     rlevel,
`ifdef RD_ALMOST_EMPTY_EN
    output logic              raempty,
`endif
    fifo_rd_ctrl_if.master    rd
);

    localparam int unsigned PW = addr + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = int'(PW) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0]   rbin;
    logic            valid_q;
    logic [data-1:0] data_q;

    logic [PW-1:0]   wbin_c;
    logic            pop_c;
    logic [PW-1:0]   rbin_nxt_c;

    // Pull a word whenever memory has one and the output register is free or being accepted.
    always_comb begin
        wbin_c     = gray2bin(rq2_wptr);
        pop_c      = !rempty && (!valid_q || rd.rd_ready);
        rbin_nxt_c = rbin + PW'(pop_c);
    end

    assign raddr       = rbin[addr-1:0];
    assign rlevel      = wbin_c - rbin;
    assign rd.rd_valid = valid_q;
    assign rd.rd_data  = data_q;

    // Read pointer, empty flag and output register.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            rbin   <= rbin_nxt_c;
            rptr   <= bin2gray(rbin_nxt_c);
            rempty <= (bin2gray(rbin_nxt_c) == rq2_wptr);
            if (pop_c) begin
                valid_q <= 1'b1;
                data_q  <= mem_rdata;
            end else if (rd.rd_ready) begin
                // Accepted with nothing to replace it; data keeps its last value.
                valid_q <= 1'b0;
            end
        end
    end

`ifdef RD_ALMOST_EMPTY_EN
    // Level after this cycle's pop compared against the threshold.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            raempty <= 1'b1;
        end else begin
            raempty <= ((wbin_c - rbin_nxt_c) <= PW'(AE_LEVEL));
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: cycle table for the single-word and
// hold cases, hand sequences for back-pressure, full drain, wrap, reset and
// almost-empty; a scoreboard checks every accepted word in order.
module tb_fifo_rd_ctrl;

    localparam int unsigned DW = 14;
    localparam int unsigned AW = 4;
    localparam int unsigned PW = 5;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic [PW-1:0] rq2_wptr;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] raddr;
    logic [PW-1:0] rptr;
    logic          rempty;
    logic [PW-1:0] rlevel;
`ifdef RD_ALMOST_EMPTY_EN
    logic          raempty;
`endif

    fifo_rd_ctrl_if #(.data(DW)) rd_if ();

    fifo_rd_ctrl #(.data(DW), .addr(AW)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rq2_wptr  (rq2_wptr),
        .mem_rdata (mem_rdata),
        .raddr     (raddr),
        .rptr      (rptr),
        .rempty    (rempty),
        .rlevel    (rlevel),
`ifdef RD_ALMOST_EMPTY_EN
        .raempty   (raempty),
`endif
        .rd        (rd_if)
    );

    always #5 rclk = ~rclk;

    logic [DW-1:0] mem [16];
    assign mem_rdata = mem[raddr];

    logic [DW-1:0] sb [$];
    logic [DW-1:0] sb_exp;
    logic [PW-1:0] wcount;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          wr;
        logic [DW-1:0] wdat;
        logic          rdy;
        logic          exp_empty;
        logic          exp_valid;
        logic [PW-1:0] exp_rptr;
        logic [PW-1:0] exp_level;
        logic          chk_data;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t          vecs [11];
    logic [AW-1:0] wrap_addr [4];
    logic [PW-1:0] wrap_ptr [4];
    logic [DW-1:0] w [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    // Store a word in the memory model, expect it downstream, publish the write pointer.
    task automatic write_word(input logic [DW-1:0] v);
        mem[wcount[AW-1:0]] = v;
        sb.push_back(v);
        wcount   = wcount + 5'd1;
        rq2_wptr = wcount ^ (wcount >> 1);
    endtask

    task automatic do_reset();
        rrst_n          = 1'b0;
        rq2_wptr        = '0;
        wcount          = '0;
        rd_if.rd_ready  = 1'b0;
        sb.delete();
        tick();
        tick();
        rrst_n = 1'b1;
    endtask

    // Scoreboard: every handshake at the next rising edge must carry the oldest expected word.
    always @(negedge rclk) begin
        if (rrst_n && rd_if.rd_valid && rd_if.rd_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got word 0x%0h, expected none", rd_if.rd_data);
            end else begin
                sb_exp = sb.pop_front();
                check("sb_data", 32'(rd_if.rd_data), 32'(sb_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        //          wr  wdat     rdy empty valid rptr   level  chk data
        vecs[0]  = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 14'h000};
        vecs[1]  = '{1'b1, 14'h1A5, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 14'h000};
        vecs[2]  = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b1, 5'd1, 5'd0, 1'b1, 14'h1A5};
        vecs[3]  = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 1'b1, 14'h1A5};
        vecs[4]  = '{1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 1'b1, 14'h1A5};
        vecs[5]  = '{1'b1, 14'h2B3, 1'b0, 1'b0, 1'b0, 5'd1, 5'd1, 1'b1, 14'h1A5};
        vecs[6]  = '{1'b0, 14'h000, 1'b0, 1'b1, 1'b1, 5'd3, 5'd0, 1'b1, 14'h2B3};
        vecs[7]  = '{1'b0, 14'h000, 1'b0, 1'b1, 1'b1, 5'd3, 5'd0, 1'b1, 14'h2B3};
        vecs[8]  = '{1'b1, 14'h3C4, 1'b1, 1'b0, 1'b0, 5'd3, 5'd1, 1'b1, 14'h2B3};
        vecs[9]  = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b1, 5'd2, 5'd0, 1'b1, 14'h3C4};
        vecs[10] = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 1'b1, 14'h3C4};
        wrap_addr[0] = 4'd14; wrap_addr[1] = 4'd15; wrap_addr[2] = 4'd0; wrap_addr[3] = 4'd1;
        wrap_ptr[0] = 5'b10001; wrap_ptr[1] = 5'b10000; wrap_ptr[2] = 5'b00000; wrap_ptr[3] = 5'b00001;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset state.
        rq2_wptr       = '0;
        wcount         = '0;
        rd_if.rd_ready = 1'b0;
        tick();
        check("rst_rempty", 32'(rempty), 32'd1);
        check("rst_valid", 32'(rd_if.rd_valid), 32'd0);
        check("rst_data", 32'(rd_if.rd_data), 32'd0);
        check("rst_rptr", 32'(rptr), 32'd0);
        check("rst_raddr", 32'(raddr), 32'd0);
`ifdef RD_ALMOST_EMPTY_EN
        check("rst_raempty", 32'(raempty), 32'd1);
`endif
        rrst_n = 1'b1;

        // Single word, hold and accept/replace table.
        for (int i = 0; i < 11; i++) begin
            rd_if.rd_ready = vecs[i].rdy;
            if (vecs[i].wr) write_word(vecs[i].wdat);
            tick();
            check($sformatf("vec%0d_rempty", i), 32'(rempty), 32'(vecs[i].exp_empty));
            check($sformatf("vec%0d_valid", i), 32'(rd_if.rd_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_rptr", i), 32'(rptr), 32'(vecs[i].exp_rptr));
            check($sformatf("vec%0d_rlevel", i), 32'(rlevel), 32'(vecs[i].exp_level));
            if (vecs[i].chk_data)
                check($sformatf("vec%0d_data", i), 32'(rd_if.rd_data), 32'(vecs[i].exp_data));
        end

        // Back-pressure: output frozen on word0 for 5 clocks, then word1/word2 back-to-back.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            w[i] = DW'($urandom);
            write_word(w[i]);
        end
        tick();
        check("bp_rempty", 32'(rempty), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_data", 32'(rd_if.rd_data), 32'(w[0]));
            check("bp_valid", 32'(rd_if.rd_valid), 32'd1);
            check("bp_rlevel", 32'(rlevel), 32'd2);
            check("bp_rptr", 32'(rptr), 32'd1);
        end
        rd_if.rd_ready = 1'b1;
        tick();
        check("bp_word1", 32'(rd_if.rd_data), 32'(w[1]));
        check("bp_valid1", 32'(rd_if.rd_valid), 32'd1);
        tick();
        check("bp_word2", 32'(rd_if.rd_data), 32'(w[2]));
        check("bp_valid2", 32'(rd_if.rd_valid), 32'd1);
        check("bp_rempty2", 32'(rempty), 32'd1);
        tick();
        check("bp_valid_end", 32'(rd_if.rd_valid), 32'd0);

        // Full drain: 16 words, level DEPTH, 16 consecutive outputs.
        do_reset();
        for (int i = 0; i < 16; i++) write_word(DW'($urandom));
        #1;
        check("full_rlevel", 32'(rlevel), 32'd16);
        tick();
        check("full_rempty", 32'(rempty), 32'd0);
        rd_if.rd_ready = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            check($sformatf("drain_valid%0d", i), 32'(rd_if.rd_valid), 32'd1);
        end
        tick();
        check("drain_valid_end", 32'(rd_if.rd_valid), 32'd0);
        check("drain_rempty", 32'(rempty), 32'd1);
        check("drain_rptr", 32'(rptr), 32'(5'b11000));
        check("drain_rlevel", 32'(rlevel), 32'd0);

        // Wrap: advance to rbin=30, then 4 words cross the address and pointer wrap.
        for (int i = 0; i < 14; i++) write_word(DW'($urandom));
        repeat (18) tick();
        check("pre_wrap_raddr", 32'(raddr), 32'd14);
        check("pre_wrap_empty", 32'(rempty), 32'd1);
        for (int i = 0; i < 4; i++) write_word(DW'($urandom));
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wrap_raddr%0d", k), 32'(raddr), 32'(wrap_addr[k]));
            check($sformatf("wrap_rptr%0d", k), 32'(rptr), 32'(wrap_ptr[k]));
            if (k > 0) check($sformatf("wrap_valid%0d", k), 32'(rd_if.rd_valid), 32'd1);
            tick();
        end
        check("wrap_valid4", 32'(rd_if.rd_valid), 32'd1);
        check("wrap_raddr4", 32'(raddr), 32'd2);
        check("wrap_rempty", 32'(rempty), 32'd1);
        tick();
        check("wrap_valid_end", 32'(rd_if.rd_valid), 32'd0);

        // Reset mid-stream drops the held word immediately.
        do_reset();
        for (int i = 0; i < 3; i++) write_word(DW'($urandom));
        tick();
        tick();
        check("mid_valid_before", 32'(rd_if.rd_valid), 32'd1);
        #2;
        rrst_n = 1'b0;
        #1;
        check("mid_valid", 32'(rd_if.rd_valid), 32'd0);
        check("mid_rempty", 32'(rempty), 32'd1);
        check("mid_rptr", 32'(rptr), 32'd0);
        check("mid_data", 32'(rd_if.rd_data), 32'd0);
        check("mid_rlevel", 32'(rlevel), 32'd3);
        sb.delete();
        wcount   = '0;
        rq2_wptr = '0;
        tick();
        rrst_n = 1'b1;
        tick();
        check("post_mid_valid", 32'(rd_if.rd_valid), 32'd0);
        check("post_mid_rempty", 32'(rempty), 32'd1);

`ifdef RD_ALMOST_EMPTY_EN
        // Almost-empty threshold at levels 0..3.
        for (int lvl = 0; lvl < 4; lvl++) begin
            do_reset();
            wcount   = PW'(lvl);
            rq2_wptr = wcount ^ (wcount >> 1);
            tick();
            check($sformatf("raempty_lvl%0d", lvl), 32'(raempty), 32'(lvl <= 2));
        end
        do_reset();
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
